inv_sub_bytes_seq: RTL

Multi-cycle InvSubBytes sequencer for the AES-256 decryption round. It accepts a 128-bit state through a valid/ready handshake and time-multiplexes the 16 byte substitutions over `LANES` shared `InverseSbox` instances. It then presents the substituted state through a valid/ready output handshake. It sits between InvShiftRows and AddRoundKey in the decrypt round datapath, and trades area (`LANES` S-boxes instead of 16) for latency.

---
 rtl/aes_dec_pkg.sv | 42 ++++
 rtl/inv_sub_bytes_seq_sbox.sv | 12 +
 rtl/inv_sub_bytes_seq.sv | 116 +++++++++++
 3 files changed

// File: rtl/aes_dec_pkg.sv
// Shared AES decrypt datapath types and GF(2^8) helpers.
// Used by the InvSubBytes sequencer and its S-box lanes.
package aes_dec_pkg;

    localparam int BLOCK_BYTES = 16;

    typedef logic [127:0] aes_state_t;

    function automatic logic [7:0] gf_mul(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse, and maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            if (i != 0) r = gf_mul(r, a);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] s);
        return {s[6:0], s[7]}
             ^ {s[4:0], s[7:5]}
             ^ {s[1:0], s[7:2]}
             ^ 8'h05;
    endfunction

endpackage

// File: rtl/inv_sub_bytes_seq_sbox.sv
// AES inverse S-box: inverse affine map followed by GF(2^8) inversion.
// Purely combinational, one byte per instance.
module InverseSbox
    import aes_dec_pkg::*;
(
    input  logic [7:0] data,
    output logic [7:0] result
);

    assign result = gf_inv(inv_affine(data));

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Multi-cycle InvSubBytes: 16 byte substitutions over LANES shared S-boxes,
// with valid/ready handshakes on both sides.
module inv_sub_bytes_seq
    import aes_dec_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  aes_state_t in_state,
    output logic       out_valid,
    input  logic       out_ready,
    output aes_state_t out_state,
    output logic       busy
);

    localparam int STEPS = BLOCK_BYTES / LANES;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        HOLD
    } state_t;

    generate
        if (LANES != 1 && LANES != 2 && LANES != 4 &&
            LANES != 8 && LANES != 16) begin : g_bad_lanes
            $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt;
    logic          last;
    logic [7:0]    work     [BLOCK_BYTES];
    logic [3:0]    lane_idx [LANES];
    logic [7:0]    lane_in  [LANES];
    logic [7:0]    lane_out [LANES];

    function automatic logic [3:0] idx_of(
        input logic [CW-1:0] c,
        input int            k
    );
        return 4'(int'(c) * LANES + k);
    endfunction

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            lane_idx[k] = idx_of(cnt, k);
            lane_in[k]  = work[lane_idx[k]];
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        InverseSbox u_sbox (
            .data  (lane_in[k]),
            .result(lane_out[k])
        );
    end

    assign last = (cnt == CW'(STEPS - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)  state_d = SUB;
            SUB:     if (last)      state_d = HOLD;
            HOLD:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Substituted bytes are written back in place over the captured state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            for (int i = 0; i < BLOCK_BYTES; i++) work[i] <= 8'h00;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        cnt <= '0;
                        for (int i = 0; i < BLOCK_BYTES; i++)
                            work[i] <= in_state[127-8*i -: 8];
                    end
                end
                SUB: begin
                    for (int k = 0; k < LANES; k++)
                        work[lane_idx[k]] <= lane_out[k];
                    cnt <= last ? '0 : cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);

    always_comb begin
        out_state = '0;
        for (int i = 0; i < BLOCK_BYTES; i++)
            out_state[127-8*i -: 8] = work[i];
    end

endmodule
